// File: rtl/debounced_in_n_out.sv
// Per-channel synchroniser, debounce counter, stable register and edge detect for raw pad inputs,
// plus AND/OR reductions and tie-high/tie-low pins. Edge pulses exist only with DEBOUNCED_IN_N_OUT_EDGE_EN.
`default_nettype none

module debounced_in_n_out #(
  parameter int N_IN            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_bus,
  output logic [N_IN-1:0] state,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic            out_and,
  output logic            out_or,
  output logic            out_high,
  output logic            out_low
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // sync_q[0] samples the pad; sync_q[SYNC_STAGES-1] is the metastability-safe copy.
  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
  logic [N_IN-1:0]                  sync_last;
  logic [N_IN-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_IN-1:0]                  state_q, state_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_bus};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // NOTE: defaults first so no path through the loop leaves a signal unassigned (no latches).
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    for (int i = 0; i < N_IN; i++) begin
      if (sync_last[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        state_d[i] = sync_last[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

`ifdef DEBOUNCED_IN_N_OUT_EDGE_EN
  logic [N_IN-1:0] rise_q, fall_q;

  // Pulses are computed from the next state so they line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= state_d & ~state_q;
      fall_q <= ~state_d & state_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

  assign state    = state_q;
  assign out_and  = &state_q;
  assign out_or   = |state_q;
  assign out_high = 1'b1;
  assign out_low  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_debounced_in_n_out.sv
// Directed bench for debounced_in_n_out: default 3-channel instance driven from a step table,
// plus an 8-channel DEBOUNCE_CYCLES=1 instance and an asynchronous mid-operation reset.
`timescale 1ns/1ps

module tb_debounced_in_n_out;

`ifdef DEBOUNCED_IN_N_OUT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_bus;
  logic [2:0] state, rise, fall;
  logic       out_and, out_or, out_high, out_low;

  logic [7:0] in8;
  logic [7:0] state8, rise8, fall8;
  logic       out_and8, out_or8, out_high8, out_low8;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] cur_state = 3'b000;

  always #5 clk = ~clk;

  debounced_in_n_out dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus),
    .state(state), .rise(rise), .fall(fall),
    .out_and(out_and), .out_or(out_or), .out_high(out_high), .out_low(out_low)
  );

  debounced_in_n_out #(.N_IN(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_bus(in8),
    .state(state8), .rise(rise8), .fall(fall8),
    .out_and(out_and8), .out_or(out_or8), .out_high(out_high8), .out_low(out_low8)
  );

  // One step: drive in_val for hold edges; state switches to exp_after on edge chg (0 = never).
  typedef struct packed {
    logic [2:0] in_val;
    logic [5:0] hold;
    logic [5:0] chg;
    logic [2:0] exp_after;
  } step_t;

  localparam int N_STEPS = 14;
  step_t steps [N_STEPS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_step(input int idx, input step_t s);
    logic [2:0] exp_s, exp_r, exp_f;
    bit pulse;
    in_bus = s.in_val;
    for (int e = 1; e <= int'(s.hold); e++) begin
      @(posedge clk);
      #1;
      pulse = (s.chg != 6'd0) && (e == int'(s.chg));
      exp_s = (s.chg != 6'd0 && e >= int'(s.chg)) ? s.exp_after : cur_state;
      exp_r = (EDGE_EN && pulse) ? (s.exp_after & ~cur_state) : 3'b000;
      exp_f = (EDGE_EN && pulse) ? (~s.exp_after & cur_state) : 3'b000;
      check($sformatf("step%0d e%0d state", idx, e), state, exp_s);
      check($sformatf("step%0d e%0d rise", idx, e), rise, exp_r);
      check($sformatf("step%0d e%0d fall", idx, e), fall, exp_f);
      check($sformatf("step%0d e%0d and", idx, e), out_and, &exp_s);
      check($sformatf("step%0d e%0d or", idx, e), out_or, |exp_s);
    end
    if (s.chg != 6'd0) cur_state = s.exp_after;
  endtask

  // DEBOUNCE_CYCLES=1 instance: new level appears on edge 3 with hand-computed pulses.
  task automatic run8(input logic [7:0] val, input logic [7:0] prev,
                      input logic [7:0] exp_r, input logic [7:0] exp_f);
    in8 = val;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("n8 %0h e%0d state", val, e), state8, (e == 3) ? val : prev);
      check($sformatf("n8 %0h e%0d rise", val, e), rise8,
            (EDGE_EN && e == 3) ? exp_r : 8'h00);
      check($sformatf("n8 %0h e%0d fall", val, e), fall8,
            (EDGE_EN && e == 3) ? exp_f : 8'h00);
    end
    check($sformatf("n8 %0h and", val), out_and8, (val == 8'hFF));
    check($sformatf("n8 %0h or", val), out_or8, (val != 8'h00));
  endtask

  initial begin
    steps[0]  = '{3'b000, 6'd4,  6'd0,  3'b000};
    steps[1]  = '{3'b001, 6'd20, 6'd18, 3'b001};  // clean press
    steps[2]  = '{3'b000, 6'd20, 6'd18, 3'b000};  // release
    steps[3]  = '{3'b010, 6'd15, 6'd0,  3'b000};  // 15-cycle glitch
    steps[4]  = '{3'b000, 6'd5,  6'd0,  3'b000};
    steps[5]  = '{3'b010, 6'd16, 6'd0,  3'b000};  // 16-cycle pulse, accepted after lag
    steps[6]  = '{3'b000, 6'd2,  6'd2,  3'b010};
    steps[7]  = '{3'b000, 6'd20, 6'd16, 3'b000};
    steps[8]  = '{3'b001, 6'd10, 6'd0,  3'b000};  // bounce: 10 high
    steps[9]  = '{3'b000, 6'd1,  6'd0,  3'b000};  // 1 low
    steps[10] = '{3'b001, 6'd20, 6'd18, 3'b001};  // final high run
    steps[11] = '{3'b000, 6'd20, 6'd18, 3'b000};
    steps[12] = '{3'b111, 6'd20, 6'd18, 3'b111};  // all channels together
    steps[13] = '{3'b000, 6'd8,  6'd0,  3'b111};  // release count in progress

    rst_n  = 1'b0;
    in_bus = 3'b111;
    in8    = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", state, 3'b000);
    check("reset rise", rise, 3'b000);
    check("reset fall", fall, 3'b000);
    check("reset and", out_and, 1'b0);
    check("reset or", out_or, 1'b0);
    check("reset high", out_high, 1'b1);
    check("reset low", out_low, 1'b0);
    check("reset state8", state8, 8'h00);
    check("reset high8", out_high8, 1'b1);
    check("reset low8", out_low8, 1'b0);

    in_bus = 3'b000;
    in8    = 8'h00;
    rst_n  = 1'b1;

    for (int i = 0; i < N_STEPS; i++) run_step(i, steps[i]);

    // Asynchronous reset between edges, mid-way through the release count.
    #3;
    rst_n  = 1'b0;
    in_bus = 3'b111;
    #1;
    check("midrst state", state, 3'b000);
    check("midrst rise", rise, 3'b000);
    check("midrst fall", fall, 3'b000);
    check("midrst and", out_and, 1'b0);
    check("midrst or", out_or, 1'b0);
    check("midrst high", out_high, 1'b1);
    check("midrst low", out_low, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    cur_state = 3'b000;
    run_step(100, '{3'b111, 6'd20, 6'd18, 3'b111});

    run8(8'hA5, 8'h00, 8'hA5, 8'h00);
    run8(8'h3C, 8'hA5, 8'h18, 8'h81);
    run8(8'hFF, 8'h3C, 8'hC3, 8'h00);
    run8(8'h00, 8'hFF, 8'h00, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debounced_in_n_out.md
# debounced_in_n_out

Parametrised board-level input/output conditioning block: it takes `N_IN` asynchronous switch or pin inputs and synchronises, debounces and edge-detects each one. It drives AND/OR reductions of the clean inputs plus constant-high and constant-low pins. It sits directly behind the FPGA input pads and feeds LEDs or downstream logic, replacing the purely combinational pin-to-pin path with glitch-free, clock-domain-safe signals.

## Interface
Parameters:
- `N_IN`, default 3: number of input channels; legal range ≥ 1.
- `SYNC_STAGES`, default 2: flops in each input synchroniser; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new level must persist before it is accepted; legal range ≥ 1. Counter width is max(1, $clog2(DEBOUNCE_CYCLES)).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_bus`, input, N_IN: raw asynchronous inputs.
- `state`, output, N_IN: debounced level per channel.
- `rise`, output, N_IN: one-cycle pulse when the channel's `state` goes 0→1.
- `fall`, output, N_IN: one-cycle pulse when the channel's `state` goes 1→0.
- `out_and`, output, 1: &state.
- `out_or`, output, 1: |state.
- `out_high`, output, 1: constant 1'b1.
- `out_low`, output, 1: constant 1'b0.

## Operation
- Each channel is independent and identical: synchroniser → debounce counter → stable register → edge detect.
- **Synchroniser:** `SYNC_STAGES` flops; every flop resets to 0. `sync_i` is the last stage.
- **Debounce, per edge:**
  - If `sync_i == state[i]`: the counter clears to 0.
  - Else if the counter equals `DEBOUNCE_CYCLES-1`: `state[i]` takes `sync_i` and the counter clears to 0.
  - Else: the counter increments.
- **Glitch rejection:** any mismatch lasting fewer than `DEBOUNCE_CYCLES` consecutive cycles at `sync_i` is discarded. A single matching cycle restarts the count from 0; there is no partial credit.
- **Edge detection:** `rise[i]` and `fall[i]` are registered. They are high in exactly the cycle in which the new `state[i]` is first visible, and low otherwise. `rise` and `fall` are never both high on the same channel.
- **Reductions:** `out_and` and `out_or` are combinational from the registered `state`, so they are glitch-free.
- **Constants:** `out_high` and `out_low` are tied; they are unaffected by reset or clock.
- **Reset values:** `state`=0, `rise`=0, `fall`=0, all counters 0, all sync flops 0, `out_and`=0, `out_or`=0, `out_high`=1, `out_low`=0.
- **Reset mid-operation:** asserting `rst_n` low forces the values above immediately, independent of `clk`. Any in-progress debounce count is lost. After release, an input held at 1 produces `rise` again, after the full latency.
- **Release of reset:** the first active edge is the first `clk` rise with `rst_n`=1. No recovery handling is required beyond the synchronous deassertion done at board level.

## Timing
- **Latency:** for an input that settles before edge 1 and is held, `state` changes on edge `SYNC_STAGES + DEBOUNCE_CYCLES`. With defaults, this is edge 18.
- `rise`/`fall` assert on that same edge, for exactly one cycle.
- `out_and`/`out_or` follow `state` with zero additional cycles.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` cycles at the synchroniser output.
- **Minimum output toggle interval:** `DEBOUNCE_CYCLES` cycles per channel.
- **`DEBOUNCE_CYCLES`=1:** the block degenerates to synchroniser plus edge detect, with latency `SYNC_STAGES+1`.
- **Simultaneous events:** multiple channels may change state on the same edge, and all corresponding edge pulses assert together.

## Configuration
- **Macro:** `DEBOUNCED_IN_N_OUT_EDGE_EN`.
- **Defined:** the `rise` and `fall` registers and logic are present, as described above.
- **Undefined:** `rise` and `fall` are tied to 0 and no edge registers are synthesised. All other behaviour is unchanged.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_bus`=3'b111 → `state`=0, `out_and`=0, `out_or`=0, `out_high`=1, `out_low`=0, no pulses.
- **Single clean press:** with defaults, `in_bus` 3'b000→3'b001, held → `state`=3'b001 and `rise`=3'b001 on edge 18 only, and `out_or`=1 from edge 18. Release the input → `fall`=3'b001 18 edges later.
- **Glitch rejection:** drive `in_bus[1]` high for 15 cycles, then low → `state` stays 0 and there are no pulses. Repeat with 16 cycles → accepted.
- **Bounce restart:** drive the pattern 10 cycles high, 1 low, 16 high → `state` rises on edge 2+16 counted from the start of the final high run.
- **All channels together:** `in_bus`=3'b111 simultaneously → `state`=3'b111, `rise`=3'b111 on the same edge, `out_and`=1. Then assert `rst_n` low for one cycle mid-way through a later release count → everything returns to 0, then `rise`=3'b111 again 18 edges after reset release.
- **Config and parameters:** build without `DEBOUNCED_IN_N_OUT_EDGE_EN` → `rise`/`fall` are always 0. Build with `N_IN`=8, `DEBOUNCE_CYCLES`=1 → latency is 3 edges per channel.
